led_level_ctrl: RTL and testbench
=================================

# led_level_ctrl

Brightness controller that sits directly upstream of the LED dimmer rotators. It divides the system clock into a slow `tick` strobe, counts PWM slots, and holds a user-adjustable brightness level stepped by two push-buttons. It drives a PWM output whose duty cycle is level/PERIOD, and exposes `tick` so the downstream dimmer stage can advance on the same cadence.

## Interface
- `DIV`, 4: clk cycles per `tick`; must be ≥2.
- `PERIOD`, 5: PWM slots per period; must be ≥2.
- `LW`, 3: width of `slot`/`level`; must satisfy 2^LW > PERIOD.
- `DEB`, 8: consecutive stable samples required to accept a button change; must be ≥1.
- `LEVEL_INIT`, 1: level after reset, in the range 0..PERIOD.

Ports:
- `clk` in 1: system clock, all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_up` in 1: raw asynchronous button input, increments the level.
- `btn_dn` in 1: raw asynchronous button input, decrements the level.
- `tick` out 1: one-clk strobe every DIV clks; feeds the dimmer stage.
- `slot` out LW: current PWM slot, 0..PERIOD-1.
- `level` out LW: requested brightness, 0..PERIOD.
- `pwm_o` out 1: PWM output.

## Operation
- Reset values: prescaler=0, `tick`=0, `slot`=0, `level`=LEVEL_INIT, active level=LEVEL_INIT, synchronizer and debounce state=0, and `pwm_o`=(LEVEL_INIT>0).
- Each button passes through a 2-flop synchronizer, then the debouncer, then a rising-edge detector on the debounced value.
- Debouncer, per button: a counter increments while the synchronized value ≠ the debounced value and clears otherwise. When the count reaches DEB, the debounced value flips and the counter clears.
- Up edge: `level` increments, saturating at PERIOD.
- Down edge: `level` decrements, saturating at 0.
- Up and down edges in the same cycle: `level` is unchanged.
- Prescaler: counts 0..DIV-1 and wraps. `tick` is registered and is 1 for exactly the cycle following prescaler==DIV-1.
- On each `tick`, `slot` increments; PERIOD-1 wraps to 0.
- Active level: loaded from `level` on the tick that wraps `slot` to 0. A level change therefore never alters the current period, which prevents mid-period glitches.
- `pwm_o` is registered each clk as (next slot < next active level). It is high for exactly active-level slots per period: level 0 is constant low, and level PERIOD is constant high.
- Level arithmetic is done in LW+1 bits before saturation, so wrap-around is impossible.

## Timing
- A button input that is high at clk edge 0 and then stays high:
  - synchronized at edge 1;
  - debounced at edge DEB+1;
  - `level` updated after edge DEB+2.
- Bounce shorter than DEB clean samples is ignored.
- `tick` period is exactly DIV clks, with a duty of 1 clk.
- PWM period is DIV×PERIOD clks.
- `slot`, `pwm_o` and the active level change only on `tick`.
- A new level first affects `pwm_o` in the period starting at the next slot wrap.
- `rst_n` low forces every register to its reset value immediately, independent of `clk`, including mid-period and mid-debounce. Release is synchronous to `clk`; the first `tick` follows DIV clks after release.

## Configuration
- `LED_LEVEL_DEBOUNCE_EN` defined: the debouncer is present as described above.
- `LED_LEVEL_DEBOUNCE_EN` undefined: the debounced value equals the synchronizer output. `level` updates after edge 2, the DEB parameter is ignored, and no debounce counters are built.

## Test plan
Parameters are defaults, with the macro defined unless stated.
- Reset, then free-run 60 clks: `tick` pulses every 4 clks; `slot` steps 0→4→0; `pwm_o` is high 4 of every 20 clks (level 1).
- Hold `btn_up` for 20 clks: `level` reaches 2 after edge 10. The duty stays 4/20 until the next slot wrap, then becomes 8/20.
- Give 6 clean up presses: `level` saturates at 5 and `pwm_o` is constant high. Then give 6 down presses: `level`=0 and `pwm_o` is constant low.
- Toggle `btn_up` every 3 clks for 30 clks, then release: `level` stays 1.
- Assert `btn_up` and `btn_dn` in the same cycle, held 20 clks: `level` stays 1.
- Pulse `rst_n` low for 2 clks at slot 3 while `level`=4: all outputs take their reset values immediately (`level`=1, `slot`=0, `tick`=0, `pwm_o`=1).
- With the macro undefined, hold `btn_up` high from edge 0: `level`=2 after edge 2.

Source files
------------

// File: rtl/led_level_ctrl.sv
// Brightness level controller: debounced up/down buttons step a level that drives a tick-aligned PWM.
// Define LED_LEVEL_DEBOUNCE_EN to build the per-button debounce counters; otherwise the synchronizer feeds the edge detector directly.
module led_level_ctrl #(
  parameter int DIV        = 4,
  parameter int PERIOD     = 5,
  parameter int LW         = 3,
  parameter int DEB        = 8,
  parameter int LEVEL_INIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          btn_up,
  input  logic          btn_dn,
  output logic          tick,
  output logic [LW-1:0] slot,
  output logic [LW-1:0] level,
  output logic          pwm_o
);

  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [LW-1:0] SLOT_LAST = LW'(PERIOD - 1);
  localparam logic [LW-1:0] LVL_RST   = LW'(LEVEL_INIT);
  localparam logic [LW:0]   LVL_MAX   = (LW + 1)'(PERIOD);
  localparam logic          PWM_RST   = (LEVEL_INIT > 0);

  if (DIV < 2 || PERIOD < 2 || DEB < 1 || (2 ** LW) <= PERIOD ||
      LEVEL_INIT < 0 || LEVEL_INIT > PERIOD) begin : g_bad_params
    $error("led_level_ctrl: illegal parameter set");
  end

  // One extra bit of headroom so the increment can be clamped before it is truncated.
  function automatic logic [LW-1:0] step_level(input logic [LW-1:0] cur,
                                               input logic up, input logic dn);
    logic [LW:0] wide;
    wide = {1'b0, cur};
    if (up && !dn) begin
      wide = wide + (LW + 1)'(1);
      if (wide > LVL_MAX) wide = LVL_MAX;
    end else if (dn && !up) begin
      wide = (wide == '0) ? '0 : wide - (LW + 1)'(1);
    end
    return wide[LW-1:0];
  endfunction

  logic [1:0] btn_raw;
  logic [1:0] sync_p0, sync_p1;
  logic [1:0] deb, deb_q, rise;

  assign btn_raw = {btn_dn, btn_up};

  // stage p0/p1: two-flop synchronizer, bit 0 = up, bit 1 = down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef LED_LEVEL_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

  logic [CW-1:0] cnt [2];

  // debounce: flip only after DEB consecutive samples disagree with the held value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb    <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_p1[b] == deb[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          deb[b] <= ~deb[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end
`else
  assign deb = sync_p1;
`endif

  assign rise = deb & ~deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      level <= LVL_RST;
    end else begin
      deb_q <= deb;
      level <= step_level(level, rise[0], rise[1]);
    end
  end

  logic [PW-1:0] pre;
  logic [LW-1:0] active;
  logic [LW-1:0] slot_nx, active_nx;

  // The active level is only swapped at the slot wrap so a period is never cut short.
  always_comb begin
    slot_nx   = slot;
    active_nx = active;
    if (tick) begin
      if (slot == SLOT_LAST) begin
        slot_nx   = '0;
        active_nx = level;
      end else begin
        slot_nx = slot + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      tick   <= 1'b0;
      slot   <= '0;
      active <= LVL_RST;
      pwm_o  <= PWM_RST;
    end else begin
      pre    <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
      tick   <= (pre == PRE_LAST);
      slot   <= slot_nx;
      active <= active_nx;
      pwm_o  <= (slot_nx < active_nx);
    end
  end

endmodule

// File: tb/tb_led_level_ctrl.sv
// Bench for led_level_ctrl: stimulus table, hand-written latency/reset sequences and random
// button traffic, all checked every cycle against an arithmetic reference model.
module tb_led_level_ctrl;

  localparam int DIV        = 4;
  localparam int PERIOD     = 5;
  localparam int LW         = 3;
  localparam int DEB        = 8;
  localparam int LEVEL_INIT = 1;
  localparam int MAXN       = 8192;
`ifdef LED_LEVEL_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int LAT    = DEB + 2;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int LAT    = 2;
`endif

  logic          clk;
  logic          rst_n;
  logic          btn_up;
  logic          btn_dn;
  logic          tick;
  logic [LW-1:0] slot;
  logic [LW-1:0] level;
  logic          pwm_o;

  led_level_ctrl #(
    .DIV(DIV), .PERIOD(PERIOD), .LW(LW), .DEB(DEB), .LEVEL_INIT(LEVEL_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn),
    .tick(tick), .slot(slot), .level(level), .pwm_o(pwm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: n counts clock edges since reset release; hin holds raw button samples,
  // hd the debounced value after each edge (index 0 = up, 1 = down).
  int n, m_level, m_active;
  int hin [2][MAXN];
  int hd  [2][MAXN];

  function automatic int in_at(int b, int e);
    if (e < 1 || e >= MAXN) return 0;
    return hin[b][e];
  endfunction

  function automatic int d_at(int b, int e);
    if (e < 0 || e >= MAXN) return 0;
    return hd[b][e];
  endfunction

  function automatic int exp_slot();
    return (n == 0) ? 0 : ((n - 1) / DIV) % PERIOD;
  endfunction

  function automatic int exp_tick();
    return (n >= DIV && n % DIV == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    n        = 0;
    m_level  = LEVEL_INIT;
    m_active = LEVEL_INIT;
    hd[0][0] = 0;
    hd[1][0] = 0;
  endtask

  task automatic model_edge(input logic up, input logic dn);
    int  old_level;
    bit  flip, r_up, r_dn;
    n++;
    if (n >= MAXN) begin
      $display("FAIL model_capacity: edge %0d exceeds %0d", n, MAXN);
      $fatal(1);
    end
    hin[0][n] = up;
    hin[1][n] = dn;
    for (int b = 0; b < 2; b++) begin
      if (DEB_ON) begin
        flip = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (in_at(b, n - 2 - j) == d_at(b, n - 1)) flip = 1'b0;
        hd[b][n] = flip ? 1 - d_at(b, n - 1) : d_at(b, n - 1);
      end else begin
        hd[b][n] = in_at(b, n - 1);
      end
    end
    r_up = (d_at(0, n - 1) == 1) && (d_at(0, n - 2) == 0);
    r_dn = (d_at(1, n - 1) == 1) && (d_at(1, n - 2) == 0);
    old_level = m_level;
    if (r_up && !r_dn)      m_level = (m_level + 1 > PERIOD) ? PERIOD : m_level + 1;
    else if (r_dn && !r_up) m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
    if (n - 1 >= DIV && (n - 1) % DIV == 0 && ((n - 1) / DIV) % PERIOD == 0)
      m_active = old_level;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, want %0d", name, n, act, exp);
    end
  endtask

  task automatic check_outputs();
    check("tick", int'(tick), exp_tick());
    check("slot", int'(slot), exp_slot());
    check("level", int'(level), m_level);
    check("pwm_o", int'(pwm_o), (exp_slot() < m_active) ? 1 : 0);
  endtask

  task automatic step(input logic up, input logic dn);
    btn_up = up;
    btn_dn = dn;
    @(posedge clk);
    #1;
    model_edge(up, dn);
    check_outputs();
  endtask

  task automatic press(input logic up, input logic dn);
    repeat (20) step(up, dn);
    repeat (20) step(1'b0, 1'b0);
  endtask

  typedef struct {
    logic up;
    logic dn;
    int   cycles;
    int   exp_level;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic up, input logic dn, input int cycles, input int exp_level);
    vec_t v;
    v.up = up; v.dn = dn; v.cycles = cycles; v.exp_level = exp_level;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lvl, tries, len;
    bit found;
    logic ru, rd;

    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Directed table: idle, single press, saturation both ways, bounce, simultaneous buttons.
    lvl = LEVEL_INIT;
    add(1'b0, 1'b0, 60, lvl);
    lvl = lvl + 1;
    add(1'b1, 1'b0, 20, lvl);
    add(1'b0, 1'b0, 20, lvl);
    for (int i = 0; i < 6; i++) begin
      lvl = (lvl + 1 > PERIOD) ? PERIOD : lvl + 1;
      add(1'b1, 1'b0, 20, lvl);
      add(1'b0, 1'b0, 20, lvl);
    end
    for (int i = 0; i < 6; i++) begin
      lvl = (lvl - 1 < 0) ? 0 : lvl - 1;
      add(1'b0, 1'b1, 20, lvl);
      add(1'b0, 1'b0, 20, lvl);
    end
    lvl = lvl + 1;
    add(1'b1, 1'b0, 20, lvl);
    add(1'b0, 1'b0, 20, lvl);
    for (int i = 0; i < 5; i++) begin
      if (!DEB_ON) lvl = (lvl + 1 > PERIOD) ? PERIOD : lvl + 1;
      add(1'b1, 1'b0, 3, lvl);
      add(1'b0, 1'b0, 3, lvl);
    end
    add(1'b0, 1'b0, 20, lvl);
    while (lvl > 1) begin
      lvl = lvl - 1;
      add(1'b0, 1'b1, 20, lvl);
      add(1'b0, 1'b0, 20, lvl);
    end
    add(1'b1, 1'b1, 20, lvl);
    add(1'b0, 1'b0, 20, lvl);

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].cycles) step(tbl[i].up, tbl[i].dn);
      check("tbl_level", int'(level), tbl[i].exp_level);
    end

    // Press latency: level must hold until exactly LAT edges after the first high sample.
    for (int i = 0; i <= LAT; i++) begin
      step(1'b1, 1'b0);
      check("latency_level", int'(level), (i == LAT) ? 2 : 1);
    end
    repeat (20) step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);

    // Random button traffic.
    for (int s = 0; s < 80; s++) begin
      ru  = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 24);
      repeat (len) step(ru, rd);
    end
    repeat (30) step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a period with level 4.
    tries = 0;
    while (m_level != 4 && tries < 12) begin
      press(m_level < 4, m_level > 4);
      tries++;
    end
    check("prep_level", int'(level), 4);
    found = 1'b0;
    for (int i = 0; i < 3 * DIV * PERIOD && !found; i++) begin
      step(1'b0, 1'b0);
      if (exp_slot() == 3) found = 1'b1;
    end
    check("slot3_reached", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_level", int'(level), LEVEL_INIT);
    check("rst_pwm", int'(pwm_o), 1);
    @(posedge clk);
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs();
    repeat (2 * DIV * PERIOD) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
